// File: rtl/tile_move_engine.sv
// rtl/tile_move_engine.sv - 2048 next-state engine: slide/merge, tile spawn, win/lose evaluation
module tile_move_engine #(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter bit         SPAWN_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dir_valid,
    input  logic [1:0]            dir,
    output logic                  dir_ready,
    input  logic [3:0][3:0][11:0] matrix_in,
    output logic [3:0][3:0][11:0] matrix_out,
    output logic                  out_valid,
    output logic                  moved,
    output logic                  win,
    output logic                  lose,
    output logic [15:0]           score
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SLIDE,
        S_SPAWN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [11:0] MAX_TILE = 12'd2048;

    state_t                  state;
    state_t                  state_next;
    logic [3:0][3:0][11:0]   board;
    logic [1:0]              dir_r;
    logic [1:0]              idx;
    logic                    moved_acc;
    logic [15:0]             score_acc;
    logic [3:0]              spawn_base;
    logic [3:0]              spawn_cnt;
    logic [7:0]              lfsr;
    logic                    lfsr_fb;

    logic [3:0][11:0]        line;
    logic [4:0][11:0]        cmp;
    logic [3:0][11:0]        res;
    logic [2:0]              cnt;
    logic [1:0]              n;
    logic                    skip;
    logic [15:0]             line_score;
    logic                    line_changed;
    logic [3:0][3:0][11:0]   slid;

    logic [3:0]              spawn_cell;
    logic                    spawn_empty;
    logic [11:0]             spawn_val;

    logic                    any_empty;
    logic                    any_pair;
    logic                    win_c;
    logic                    lose_c;

    // x^8+x^6+x^5+x^4+1, free-running so spawn position depends on timing history
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (dir_valid) state_next = S_LOAD;
            S_LOAD:  state_next = S_SLIDE;
            S_SLIDE: begin
                if (idx == 2'd3) begin
                    state_next = (SPAWN_EN && (moved_acc || line_changed)) ? S_SPAWN : S_CHECK;
                end
            end
            S_SPAWN: if (spawn_empty || spawn_cnt == 4'd15) state_next = S_CHECK;
            S_CHECK: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dir_ready = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Line k is read in leading-edge order so one compactor serves all four directions
    always_comb begin
        line       = '0;
        cmp        = '0;
        res        = '0;
        cnt        = '0;
        n          = '0;
        skip       = 1'b0;
        line_score = '0;
        for (int p = 0; p < 4; p++) begin
            case (dir_r)
                2'b00:   line[p] = board[p][idx];
                2'b01:   line[p] = board[3-p][idx];
                2'b10:   line[p] = board[idx][p];
                default: line[p] = board[idx][3-p];
            endcase
        end
        for (int p = 0; p < 4; p++) begin
            if (line[p] != '0) begin
                cmp[cnt] = line[p];
                cnt      = cnt + 3'd1;
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (cmp[p] != '0) begin
                if (cmp[p] == cmp[p+1] && cmp[p] != MAX_TILE) begin
                    res[n]     = {cmp[p][10:0], 1'b0};
                    line_score = line_score + {3'b000, cmp[p], 1'b0};
                    skip       = 1'b1;
                end else begin
                    res[n] = cmp[p];
                end
                n = n + 2'd1;
            end
        end
        line_changed = (res != line);
        slid = board;
        for (int p = 0; p < 4; p++) begin
            case (dir_r)
                2'b00:   slid[p][idx]   = res[p];
                2'b01:   slid[3-p][idx] = res[p];
                2'b10:   slid[idx][p]   = res[p];
                default: slid[idx][3-p] = res[p];
            endcase
        end
    end

    always_comb begin
        spawn_cell  = spawn_base + spawn_cnt;
        spawn_empty = (board[spawn_cell[3:2]][spawn_cell[1:0]] == '0);
        spawn_val   = (lfsr[6:4] == 3'b111) ? 12'd4 : 12'd2;
    end

    always_comb begin
        any_empty = 1'b0;
        any_pair  = 1'b0;
        win_c     = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board[r][c] == '0) any_empty = 1'b1;
                if (board[r][c] == MAX_TILE) win_c = 1'b1;
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (board[r][c] == board[r][c+1]) any_pair = 1'b1;
                if (board[c][r] == board[c+1][r]) any_pair = 1'b1;
            end
        end
        lose_c = !any_empty && !any_pair;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr       <= LFSR_SEED;
            board      <= '0;
            dir_r      <= '0;
            idx        <= '0;
            moved_acc  <= 1'b0;
            score_acc  <= '0;
            spawn_base <= '0;
            spawn_cnt  <= '0;
            matrix_out <= '0;
            moved      <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
            score      <= '0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            case (state)
                S_IDLE: begin
                    if (dir_valid) begin
                        board <= matrix_in;
                        dir_r <= dir;
                    end
                end
                S_LOAD: begin
                    moved_acc <= 1'b0;
                    idx       <= '0;
                end
                S_SLIDE: begin
                    board      <= slid;
                    moved_acc  <= moved_acc | line_changed;
                    score_acc  <= score_acc + line_score;
                    idx        <= idx + 2'd1;
                    spawn_base <= lfsr[3:0];
                    spawn_cnt  <= '0;
                end
                S_SPAWN: begin
                    if (spawn_empty) begin
                        board[spawn_cell[3:2]][spawn_cell[1:0]] <= spawn_val;
                    end
                    spawn_cnt <= spawn_cnt + 4'd1;
                end
                S_CHECK: begin
                    // Results land on the edge into DONE so they coincide with out_valid
                    matrix_out <= board;
                    moved      <= moved_acc;
                    win        <= win_c;
                    lose       <= lose_c;
                    score      <= score_acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_move_engine.sv
// tb/tb_tile_move_engine.sv - directed vector bench for tile_move_engine
module tb_tile_move_engine;

    typedef logic [3:0][3:0][11:0] board_t;
    typedef struct {
        logic [1:0]  d;
        board_t      bin;
        board_t      bexp;
        logic        mv;
        logic        w;
        logic        l;
        logic [15:0] sc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        dir_valid0, dir_ready0, out_valid0, moved0, win0, lose0;
    logic [1:0]  dir0;
    board_t      matrix_in0, matrix_out0;
    logic [15:0] score0;

    logic        dir_valid1, dir_ready1, out_valid1, moved1, win1, lose1;
    logic [1:0]  dir1;
    board_t      matrix_in1, matrix_out1;
    logic [15:0] score1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tile_move_engine #(.LFSR_SEED(8'hA5), .SPAWN_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .dir_valid(dir_valid0), .dir(dir0), .dir_ready(dir_ready0),
        .matrix_in(matrix_in0), .matrix_out(matrix_out0), .out_valid(out_valid0),
        .moved(moved0), .win(win0), .lose(lose0), .score(score0)
    );

    tile_move_engine #(.LFSR_SEED(8'h3C), .SPAWN_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .dir_valid(dir_valid1), .dir(dir1), .dir_ready(dir_ready1),
        .matrix_in(matrix_in1), .matrix_out(matrix_out1), .out_valid(out_valid1),
        .moved(moved1), .win(win1), .lose(lose1), .score(score1)
    );

    function automatic logic [3:0][11:0] row4(input int a, input int b, input int c, input int d);
        logic [3:0][11:0] r;
        r[0] = a[11:0];
        r[1] = b[11:0];
        r[2] = c[11:0];
        r[3] = d[11:0];
        return r;
    endfunction

    function automatic board_t bd(input logic [3:0][11:0] r0, input logic [3:0][11:0] r1,
                                  input logic [3:0][11:0] r2, input logic [3:0][11:0] r3);
        board_t b;
        b[0] = r0;
        b[1] = r1;
        b[2] = r2;
        b[3] = r3;
        return b;
    endfunction

    function automatic board_t checker_board();
        board_t b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
        return b;
    endfunction

    function automatic vec_t mkv(input logic [1:0] d, input board_t bin, input board_t bexp,
                                 input logic mv, input logic w, input logic l, input int sc);
        vec_t v;
        v.d    = d;
        v.bin  = bin;
        v.bexp = bexp;
        v.mv   = mv;
        v.w    = w;
        v.l    = l;
        v.sc   = sc[15:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_move(input bit sel, input logic [1:0] d, input board_t b, output int lat);
        @(negedge clk);
        chk("ready_before_move", sel ? dir_ready1 : dir_ready0, 1'b1);
        if (sel) begin
            dir1 = d; matrix_in1 = b; dir_valid1 = 1'b1;
        end else begin
            dir0 = d; matrix_in0 = b; dir_valid0 = 1'b1;
        end
        @(negedge clk);
        dir_valid0 = 1'b0;
        dir_valid1 = 1'b0;
        lat = 1;
        while (!(sel ? out_valid1 : out_valid0) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        vec_t             tv[12];
        board_t           z4, colb, b, act, other;
        logic [3:0][11:0] zr;
        int               lat, pulses;
        logic [11:0]      v;

        dir_valid0 = 1'b0; dir0 = '0; matrix_in0 = '0;
        dir_valid1 = 1'b0; dir1 = '0; matrix_in1 = '0;
        zr   = row4(0, 0, 0, 0);
        z4   = '0;
        colb = bd(row4(2, 0, 0, 0), row4(2, 0, 0, 0), row4(4, 0, 0, 0), zr);

        tv[0]  = mkv(2'b10, bd(row4(2, 2, 2, 2), zr, zr, zr), bd(row4(4, 4, 0, 0), zr, zr, zr), 1, 0, 0, 8);
        tv[1]  = mkv(2'b00, colb, bd(row4(4, 0, 0, 0), row4(4, 0, 0, 0), zr, zr), 1, 0, 0, 12);
        tv[2]  = mkv(2'b01, colb, bd(zr, zr, row4(4, 0, 0, 0), row4(4, 0, 0, 0)), 1, 0, 0, 16);
        tv[3]  = mkv(2'b10, bd(row4(1024, 1024, 0, 0), zr, zr, zr), bd(row4(2048, 0, 0, 0), zr, zr, zr), 1, 1, 0, 2064);
        tv[4]  = mkv(2'b10, bd(row4(2048, 2048, 0, 0), zr, zr, zr), bd(row4(2048, 2048, 0, 0), zr, zr, zr), 0, 1, 0, 2064);
        tv[5]  = mkv(2'b00, checker_board(), checker_board(), 0, 0, 1, 2064);
        tv[6]  = mkv(2'b01, checker_board(), checker_board(), 0, 0, 1, 2064);
        tv[7]  = mkv(2'b10, checker_board(), checker_board(), 0, 0, 1, 2064);
        tv[8]  = mkv(2'b11, checker_board(), checker_board(), 0, 0, 1, 2064);
        tv[9]  = mkv(2'b10, bd(zr, row4(4, 0, 4, 8), zr, zr), bd(zr, row4(8, 8, 0, 0), zr, zr), 1, 0, 0, 2072);
        tv[10] = mkv(2'b11, bd(row4(2, 2, 4, 0), zr, zr, zr), bd(row4(0, 0, 4, 4), zr, zr, zr), 1, 0, 0, 2076);
        tv[11] = mkv(2'b11, bd(row4(2, 2, 2, 2), zr, zr, zr), bd(row4(0, 0, 4, 4), zr, zr, zr), 1, 0, 0, 2084);

        repeat (2) @(negedge clk);
        chk("rst_matrix_out", matrix_out0, z4);
        chk("rst_flags", {out_valid0, moved0, win0, lose0}, 4'b0000);
        chk("rst_score", score0, 16'd0);
        chk("rst_dir_ready", dir_ready0, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_move(1'b0, tv[i].d, tv[i].bin, lat);
            chk($sformatf("v%0d_latency", i), lat, 7);
            chk($sformatf("v%0d_matrix", i), matrix_out0, tv[i].bexp);
            chk($sformatf("v%0d_moved", i), moved0, tv[i].mv);
            chk($sformatf("v%0d_win", i), win0, tv[i].w);
            chk($sformatf("v%0d_lose", i), lose0, tv[i].l);
            chk($sformatf("v%0d_score", i), score0, tv[i].sc);
        end

        // Right move on a full board leaves only [0][0] open for the spawn
        b = bd(row4(2, 2, 4, 8), row4(16, 32, 64, 128), row4(256, 512, 16, 32), row4(64, 128, 256, 512));
        do_move(1'b1, 2'b11, b, lat);
        chk("spawn_latency_range", (lat >= 8 && lat <= 23), 1'b1);
        act = matrix_out1;
        v = act[0][0];
        act[0][0] = '0;
        chk("spawn_value", (v == 12'd2 || v == 12'd4), 1'b1);
        b[0] = row4(0, 4, 4, 8);
        chk("spawn_rest", act, b);
        chk("spawn_flags", {moved1, win1, lose1}, 3'b100);
        chk("spawn_score", score1, 16'd4);

        do_move(1'b1, 2'b10, checker_board(), lat);
        chk("spawn_en_nomove_latency", lat, 7);
        chk("spawn_en_nomove_matrix", matrix_out1, checker_board());
        chk("spawn_en_nomove_flags", {moved1, win1, lose1}, 3'b001);

        // Reset in the middle of a slide
        @(negedge clk);
        dir0 = 2'b10; matrix_in0 = tv[0].bin; dir_valid0 = 1'b1;
        @(negedge clk);
        chk("busy_ready", dir_ready0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        dir_valid0 = 1'b0;
        #1;
        chk("midrst_matrix_out", matrix_out0, z4);
        chk("midrst_flags", {out_valid0, moved0, win0, lose0}, 4'b0000);
        chk("midrst_score", score0, 16'd0);
        chk("midrst_dir_ready", dir_ready0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Fresh move after reset, with a second request pulsed while busy
        other = bd(row4(2048, 0, 0, 0), row4(2, 2, 0, 0), zr, zr);
        @(negedge clk);
        dir0 = 2'b10; matrix_in0 = tv[0].bin; dir_valid0 = 1'b1;
        @(negedge clk);
        dir_valid0 = 1'b0;
        lat = 1;
        @(negedge clk);
        lat = 2;
        dir0 = 2'b11; matrix_in0 = other; dir_valid0 = 1'b1;
        chk("busy_pulse_ready", dir_ready0, 1'b0);
        @(negedge clk);
        lat = 3;
        dir_valid0 = 1'b0;
        while (!out_valid0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("postrst_latency", lat, 7);
        chk("postrst_matrix", matrix_out0, tv[0].bexp);
        chk("postrst_score", score0, 16'd8);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid0) pulses++;
        end
        chk("busy_pulse_ignored", pulses, 0);
        chk("busy_pulse_matrix_held", matrix_out0, tv[0].bexp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
